// File: rtl/pipe_rca_pkg.sv
// -----------------------------------------------------------------------------
// pipe_rca_pkg
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   DEF_WIDTH / DEF_SEG_W : default operand width and carry-segment width
//   calc_nseg()           : number of pipeline stages (one carry segment each)
//   stage_reg_t           : layout of one stage register at the default sizes
//                           (valid, carry, partial sum, shifted operands)
// -----------------------------------------------------------------------------
package pipe_rca_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 8;

    // Number of carry segments, one per pipeline stage. A non-positive segment
    // width is reported separately at elaboration; return 1 here so that the
    // arithmetic never divides by zero.
    function automatic int calc_nseg(input int width, input int seg_w);
        if (seg_w < 1) begin
            return 1;
        end
        return width / seg_w;
    endfunction

    localparam int DEF_NSEG = calc_nseg(DEF_WIDTH, DEF_SEG_W);

    // Per-stage register. The operands are kept right-aligned: after each
    // stage they shift down by one segment so the next unresolved segment is
    // always at the bottom. Resolved sum segments enter at the top and shift
    // down, so after the last stage the sum is fully aligned.
    typedef struct packed {
        logic                 vld;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } stage_reg_t;

endpackage : pipe_rca_pkg

// File: rtl/rca_seg.sv
// -----------------------------------------------------------------------------
// rca_seg
// Combinational SEG_W-bit ripple-carry adder segment.
//   a, b     : segment operands
//   cin      : carry into bit 0
//   s        : segment sum
//   cout     : carry out of the segment MSB
//   c_msb_in : carry into the segment MSB (used for signed overflow when this
//              segment holds the operand MSB)
// -----------------------------------------------------------------------------
module rca_seg
    import pipe_rca_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    // c[i] is the carry into bit i; c[SEG_W] is the carry out.
    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[SEG_W];
    assign c_msb_in = c[SEG_W-1];

endmodule : rca_seg

// File: rtl/pipe_rca.sv
// -----------------------------------------------------------------------------
// pipe_rca
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut
// into NSEG = WIDTH/SEG_W segments; stage k resolves segment k-1 using the
// carry registered by the previous stage. One operation per cycle behind a
// valid/ready handshake, with a single global advance enable for backpressure.
//
// Ports
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : operand beat offered
//   in_ready   : beat can be accepted this cycle (= global advance enable)
//   a, b       : WIDTH-bit operands
//   cin        : carry-in, add mode only
//   sub        : 0 -> s = a + b + cin, 1 -> s = a - b
//   out_valid  : result beat present
//   out_ready  : consumer takes the result this cycle
//   s          : sum / difference
//   cout       : carry out of the MSB (in subtract mode 1 means no borrow)
//   ovf        : two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    // Refuse to build with a segment width that does not tile the operand.
    if ((SEG_W < 1) || (WIDTH < 1) || ((WIDTH % SEG_W) != 0)) begin : g_bad_cfg
        $error("pipe_rca: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
               WIDTH, SEG_W);
    end

    // Same layout as pipe_rca_pkg::stage_reg_t, sized to this instance.
    typedef struct packed {
        logic             vld;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           stg_p0;               // combinational stage-0 operand prep
    stage_t           stg_q  [1:NSEG];      // registered stages
    logic [SEG_W-1:0] seg_s  [1:NSEG];
    logic             seg_co [1:NSEG];
    logic             seg_cm [1:NSEG];
    logic             ovf_q;
    logic             en;

    // All stages move together; a stalled result freezes the whole pipe.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---- stage 0: operand conditioning (a - b = a + ~b + 1) ----
    always_comb begin
        stg_p0       = '0;
        stg_p0.vld   = in_valid;
        stg_p0.carry = sub ? 1'b1 : cin;
        stg_p0.a     = a;
        stg_p0.b     = sub ? ~b : b;
    end

    for (genvar k = 1; k <= NSEG; k++) begin : g_stage
        stage_t prv;
        stage_t nxt;

        if (k == 1) begin : g_first
            assign prv = stg_p0;
        end else begin : g_next
            assign prv = stg_q[k-1];
        end

        rca_seg #(
            .SEG_W    (SEG_W)
        ) u_seg (
            .a        (prv.a[SEG_W-1:0]),
            .b        (prv.b[SEG_W-1:0]),
            .cin      (prv.carry),
            .s        (seg_s[k]),
            .cout     (seg_co[k]),
            .c_msb_in (seg_cm[k])
        );

        // The new segment sum enters at the top of the sum field while the
        // previously resolved segments and the pending operands shift down.
        always_comb begin
            nxt       = '0;
            nxt.vld   = prv.vld;
            nxt.carry = seg_co[k];
            nxt.sum   = (prv.sum >> SEG_W) | (WIDTH'(seg_s[k]) << (WIDTH - SEG_W));
            nxt.a     = prv.a >> SEG_W;
            nxt.b     = prv.b >> SEG_W;
        end

        // ---- stage k register ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stg_q[k] <= '0;
            end else if (en) begin
                stg_q[k] <= nxt;
            end
        end

        // Only the top segment sees the operand MSB, so overflow is formed
        // here from the carries into and out of that bit.
        if (k == NSEG) begin : g_ovf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= seg_co[k] ^ seg_cm[k];
                end
            end
        end
    end

    assign out_valid = stg_q[NSEG].vld;
    assign s         = stg_q[NSEG].sum;
    assign cout      = stg_q[NSEG].carry;
    assign ovf       = ovf_q;

endmodule : pipe_rca
